hazard_scoreboard_ctrl: RTL and testbench

HAZARD_SCOREBOARD_CTRL -- requirements
Module: hazard_scoreboard_ctrl

---
 rtl/hazard_scoreboard_ctrl_pkg.sv | 25 ++
 rtl/hazard_scoreboard.sv | 82 ++++++++
 rtl/hazard_scoreboard_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_hazard_scoreboard_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_ctrl_pkg.sv
// hazard_scoreboard_ctrl_pkg
//   Types and constants shared by the hazard/scoreboard controller and its
//   scoreboard sub-module: the FSM state encoding, the fixed index of the
//   PC stall bit, and default sizing for the pipeline it serves.
package hazard_scoreboard_ctrl_pkg;

  // Controller FSM states. The encoding is visible on the debug output, so
  // the numeric values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_KILL     = 2'd3
  } hsc_state_e;

  // Bit 0 of the stall vector gates the program counter.
  localparam int PC_IDX = 0;

  // Default pipeline geometry: five stages, execute in stage 2.
  localparam int NSTAGE_DEFAULT  = 5;
  localparam int EXE_IDX_DEFAULT = 2;
  localparam int NREG_DEFAULT    = 32;
  localparam int CNT_W_DEFAULT   = 32;

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Tracks which architectural registers are waiting on a long-latency
//   (mul/div) result and decides whether the instruction in ID must wait.
//
// Ports
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_rs1_addr_id/i_rs2_addr_id    ID source registers
//   i_use_rs1_id/i_use_rs2_id      source register actually read
//   i_rd_addr_exe                  destination of the instruction in EXE
//   i_we_reg_exe/i_is_load_exe     EXE writes a register / is a load
//   i_ll_issue, i_ll_rd            long-latency op leaving ID and its rd
//   i_ll_done, i_ll_done_rd        long-latency result written back
//   o_sb_busy                      per-register busy flags (x0 never busy)
//   o_hazard                       ID must hold (load-use or busy source)
module hazard_scoreboard
  import hazard_scoreboard_ctrl_pkg::*;
#(
  parameter int NREG = NREG_DEFAULT,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [AW-1:0]   i_rs1_addr_id,
  input  logic [AW-1:0]   i_rs2_addr_id,
  input  logic            i_use_rs1_id,
  input  logic            i_use_rs2_id,
  input  logic [AW-1:0]   i_rd_addr_exe,
  input  logic            i_we_reg_exe,
  input  logic            i_is_load_exe,
  input  logic            i_ll_issue,
  input  logic [AW-1:0]   i_ll_rd,
  input  logic            i_ll_done,
  input  logic [AW-1:0]   i_ll_done_rd,
  output logic [NREG-1:0] o_sb_busy,
  output logic            o_hazard
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_next;
  logic            w_load_rd_valid;
  logic            w_rs1_hit;
  logic            w_rs2_hit;

  // The clear is applied after the set so that a register issued and
  // completed in the same cycle ends up not busy. Register 0 is hardwired
  // to zero and can never be waited on.
  always_comb begin
    w_busy_next = r_busy;
    for (int i = 1; i < NREG; i++) begin
      if (i_ll_issue && (i_ll_rd == AW'(i))) begin
        w_busy_next[i] = 1'b1;
      end
      if (i_ll_done && (i_ll_done_rd == AW'(i))) begin
        w_busy_next[i] = 1'b0;
      end
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  // A load in EXE only produces its data at the end of MEM, so any reader
  // directly behind it must wait one cycle.
  assign w_load_rd_valid = i_is_load_exe & i_we_reg_exe & (i_rd_addr_exe != '0);

  assign w_rs1_hit = i_use_rs1_id &
                     (r_busy[i_rs1_addr_id] |
                      (w_load_rd_valid & (i_rs1_addr_id == i_rd_addr_exe)));
  assign w_rs2_hit = i_use_rs2_id &
                     (r_busy[i_rs2_addr_id] |
                      (w_load_rd_valid & (i_rs2_addr_id == i_rd_addr_exe)));

  assign o_hazard  = w_rs1_hit | w_rs2_hit;
  assign o_sb_busy = r_busy;

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// hazard_scoreboard_ctrl
//   Pipeline stall/flush controller. Combines data hazards from the
//   scoreboard with memory-side stalls into a per-boundary stall chain,
//   inserts bubbles where a stalled stage feeds a moving one, and runs a
//   small FSM for branch redirects, fences and mode switches.
//
// Ports
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_rs*/i_use_rs*/i_rd_addr_exe/
//   i_we_reg_exe/i_is_load_exe     hazard inputs (see hazard_scoreboard)
//   i_ll_issue/i_ll_rd/
//   i_ll_done/i_ll_done_rd         long-latency scoreboard updates
//   i_error_prediction             branch mispredicted, redirect fetch
//   i_fence_req                    drain the pipeline, then kill younger
//   i_switch_mode                  flush everything immediately
//   i_if_stall, i_mem_stall        fetch / data memory not ready
//   o_stall[NSTAGE]                bit 0 = PC, bit k = boundary k
//   o_flush[NSTAGE]                bit k = bubble into boundary k, bit 0 = 0
//   o_sb_busy[NREG]                scoreboard flags
//   o_fsm_state[2]                 debug view of the controller state
//   o_stall_cycles[CNT_W]          saturating count of PC-stall cycles
module hazard_scoreboard_ctrl
  import hazard_scoreboard_ctrl_pkg::*;
#(
  parameter int NSTAGE  = NSTAGE_DEFAULT,
  parameter int NREG    = NREG_DEFAULT,
  parameter int EXE_IDX = EXE_IDX_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT,
  localparam int AW     = $clog2(NREG)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [AW-1:0]     i_rs1_addr_id,
  input  logic [AW-1:0]     i_rs2_addr_id,
  input  logic              i_use_rs1_id,
  input  logic              i_use_rs2_id,
  input  logic [AW-1:0]     i_rd_addr_exe,
  input  logic              i_we_reg_exe,
  input  logic              i_is_load_exe,
  input  logic              i_ll_issue,
  input  logic [AW-1:0]     i_ll_rd,
  input  logic              i_ll_done,
  input  logic [AW-1:0]     i_ll_done_rd,
  input  logic              i_error_prediction,
  input  logic              i_fence_req,
  input  logic              i_switch_mode,
  input  logic              i_if_stall,
  input  logic              i_mem_stall,
  output logic [NSTAGE-1:0] o_stall,
  output logic [NSTAGE-1:0] o_flush,
  output logic [NREG-1:0]   o_sb_busy,
  output logic [1:0]        o_fsm_state,
  output logic [CNT_W-1:0]  o_stall_cycles
);

  function automatic logic [NSTAGE-1:0] bitRange(input int lo, input int hi);
    logic [NSTAGE-1:0] m;
    m = '0;
    for (int k = lo; k <= hi; k++) begin
      m[k] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [NSTAGE-1:0] ALL_BOUNDARIES = bitRange(1, NSTAGE - 1);
  localparam logic [NSTAGE-1:0] FRONT_FLUSH    = bitRange(1, EXE_IDX);
  localparam logic [NSTAGE-1:0] FRONT_STALL    = bitRange(PC_IDX, EXE_IDX);
  localparam logic [NSTAGE-1:0] DRAIN_STALL    = bitRange(PC_IDX, EXE_IDX - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX        = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE        = CNT_W'(1);

  logic              w_hazard;
  logic [NREG-1:0]   w_sb_busy;
  logic [NSTAGE-1:0] w_base_stall;
  logic [NSTAGE-1:0] w_stall;
  logic [NSTAGE-1:0] w_kill;
  logic [NSTAGE-1:0] w_flush;
  hsc_state_e        r_state;
  hsc_state_e        w_state_next;
  logic [CNT_W-1:0]  r_stall_cycles;

  hazard_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_rs1_addr_id (i_rs1_addr_id),
    .i_rs2_addr_id (i_rs2_addr_id),
    .i_use_rs1_id  (i_use_rs1_id),
    .i_use_rs2_id  (i_use_rs2_id),
    .i_rd_addr_exe (i_rd_addr_exe),
    .i_we_reg_exe  (i_we_reg_exe),
    .i_is_load_exe (i_is_load_exe),
    .i_ll_issue    (i_ll_issue),
    .i_ll_rd       (i_ll_rd),
    .i_ll_done     (i_ll_done),
    .i_ll_done_rd  (i_ll_done_rd),
    .o_sb_busy     (w_sb_busy),
    .o_hazard      (w_hazard)
  );

  // Natural stall chain. A memory stall freezes everything from MEM back;
  // a data hazard additionally freezes everything upstream of EXE; a fetch
  // stall only holds the PC. The last boundary feeds write-back, which
  // never stalls, so a memory stall shows up there as a bubble instead.
  always_comb begin
    w_base_stall = '0;
    for (int k = 1; k < NSTAGE - 1; k++) begin
      w_base_stall[k] = (k < EXE_IDX) ? (i_mem_stall | w_hazard) : i_mem_stall;
    end
    w_base_stall[PC_IDX] = i_mem_stall | w_hazard | i_if_stall;
  end

  // Controller FSM: overrides the natural stall chain and adds kill terms.
  // A mode switch beats everything; a misprediction flushes the front end
  // and, if fetch cannot take the new PC yet, parks in REDIRECT holding the
  // PC until it can. DRAIN freezes the front end while older work retires.
  always_comb begin
    w_stall      = w_base_stall;
    w_kill       = '0;
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_REDIRECT: begin
        if (i_switch_mode) begin
          w_stall      = '0;
          w_kill       = ALL_BOUNDARIES;
          w_state_next = ST_IDLE;
        end else if (i_error_prediction || ((r_state == ST_REDIRECT) && i_if_stall)) begin
          w_stall         = w_base_stall & ~FRONT_STALL;
          w_stall[PC_IDX] = i_if_stall;
          w_kill          = FRONT_FLUSH;
          w_state_next    = i_if_stall ? ST_REDIRECT : ST_IDLE;
        end else if (r_state == ST_REDIRECT) begin
          w_state_next = ST_IDLE;
        end else if (i_fence_req) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (i_switch_mode) begin
          w_stall      = '0;
          w_kill       = ALL_BOUNDARIES;
          w_state_next = ST_IDLE;
        end else begin
          w_stall         = w_base_stall | DRAIN_STALL;
          w_kill[EXE_IDX] = 1'b1;
          if ((w_sb_busy == '0) && !i_mem_stall) begin
            w_state_next = ST_KILL;
          end
        end
      end
      // KILL: a single cycle that discards everything younger than the fence.
      default: begin
        w_stall      = '0;
        w_kill       = ALL_BOUNDARIES;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Bubble insertion: a stalled stage feeding a moving one must hand it a
  // bubble, otherwise the moving stage would duplicate its instruction.
  always_comb begin
    w_flush = w_kill;
    for (int k = 1; k < NSTAGE; k++) begin
      w_flush[k] = w_kill[k] | (w_stall[k-1] & ~w_stall[k]);
    end
    w_flush[PC_IDX] = 1'b0;
  end

  // State register. Reset drops any pending redirect or drain outright.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Performance counter of cycles the PC was held; sticks at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cycles <= '0;
    end else if (w_stall[PC_IDX] && (r_stall_cycles != CNT_MAX)) begin
      r_stall_cycles <= r_stall_cycles + CNT_ONE;
    end
  end

  assign o_stall        = w_stall;
  assign o_flush        = w_flush;
  assign o_sb_busy      = w_sb_busy;
  assign o_fsm_state    = r_state;
  assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// tb_hazard_scoreboard_ctrl
//   Drives directed scenarios followed by random traffic into the
//   controller. Each cycle the stimulus side computes what the pipeline
//   should see from a boundary-level model and queues it; a monitor on the
//   falling edge pops and compares against the DUT outputs.
module tb_hazard_scoreboard_ctrl;

  localparam int NSTAGE  = 5;
  localparam int NREG    = 32;
  localparam int EXE_IDX = 2;
  localparam int CNT_W   = 4;
  localparam int AW      = $clog2(NREG);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam int MODE_IDLE     = 0;
  localparam int MODE_REDIRECT = 1;
  localparam int MODE_DRAIN    = 2;
  localparam int MODE_KILL     = 3;

  typedef struct packed {
    logic          rstn;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          useRs1;
    logic          useRs2;
    logic [AW-1:0] rdExe;
    logic          weExe;
    logic          isLoad;
    logic          llIssue;
    logic [AW-1:0] llRd;
    logic          llDone;
    logic [AW-1:0] llDoneRd;
    logic          ep;
    logic          fence;
    logic          sw;
    logic          ifStall;
    logic          memStall;
  } stim_t;

  typedef struct packed {
    logic [NSTAGE-1:0] stall;
    logic [NSTAGE-1:0] flush;
    logic [NREG-1:0]   busy;
    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
  } expRec_t;

  logic              clk = 1'b0;
  logic              rstN;
  logic [AW-1:0]     rs1AddrId, rs2AddrId, rdAddrExe, llRd, llDoneRd;
  logic              useRs1Id, useRs2Id, weRegExe, isLoadExe;
  logic              llIssue, llDone;
  logic              errorPrediction, fenceReq, switchMode, ifStall, memStall;
  logic [NSTAGE-1:0] stallOut, flushOut;
  logic [NREG-1:0]   sbBusy;
  logic [1:0]        fsmState;
  logic [CNT_W-1:0]  stallCycles;

  int      checkCount = 0;
  int      failCount  = 0;
  int      cycNum     = 0;
  expRec_t expQ[$];
  expRec_t monExp;

  // Reference model state
  bit busyM[NREG];
  int modeM;
  int cntM;

  always #5 clk = ~clk;

  hazard_scoreboard_ctrl #(
    .NSTAGE  (NSTAGE),
    .NREG    (NREG),
    .EXE_IDX (EXE_IDX),
    .CNT_W   (CNT_W)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rstN),
    .i_rs1_addr_id      (rs1AddrId),
    .i_rs2_addr_id      (rs2AddrId),
    .i_use_rs1_id       (useRs1Id),
    .i_use_rs2_id       (useRs2Id),
    .i_rd_addr_exe      (rdAddrExe),
    .i_we_reg_exe       (weRegExe),
    .i_is_load_exe      (isLoadExe),
    .i_ll_issue         (llIssue),
    .i_ll_rd            (llRd),
    .i_ll_done          (llDone),
    .i_ll_done_rd       (llDoneRd),
    .i_error_prediction (errorPrediction),
    .i_fence_req        (fenceReq),
    .i_switch_mode      (switchMode),
    .i_if_stall         (ifStall),
    .i_mem_stall        (memStall),
    .o_stall            (stallOut),
    .o_flush            (flushOut),
    .o_sb_busy          (sbBusy),
    .o_fsm_state        (fsmState),
    .o_stall_cycles     (stallCycles)
  );

  function automatic stim_t quietStim();
    stim_t s;
    s      = '0;
    s.rstn = 1'b1;
    return s;
  endfunction

  // Which boundaries hold, by region: PC, front end (before EXE), back end.
  function automatic logic [NSTAGE-1:0] stallShape(input bit pc, input bit front, input bit back);
    logic [NSTAGE-1:0] v;
    v = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      if (k == 0)               v[k] = pc;
      else if (k < EXE_IDX)     v[k] = front;
      else if (k <= NSTAGE - 2) v[k] = back;
      else                      v[k] = 1'b0;
    end
    return v;
  endfunction

  function automatic logic [NSTAGE-1:0] bubbles(input logic [NSTAGE-1:0] st);
    logic [NSTAGE-1:0] f;
    f = '0;
    for (int k = 1; k < NSTAGE; k++) begin
      f[k] = st[k-1] && !st[k];
    end
    return f;
  endfunction

  task automatic checkField(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput(input expRec_t e);
    checkField("stall",        64'(stallOut),    64'(e.stall));
    checkField("flush",        64'(flushOut),    64'(e.flush));
    checkField("sb_busy",      64'(sbBusy),      64'(e.busy));
    checkField("fsm_state",    64'(fsmState),    64'(e.state));
    checkField("stall_cycles", 64'(stallCycles), 64'(e.cnt));
  endtask

  // Drive one cycle of inputs, predict this cycle's outputs and queue them,
  // then advance the model to what the next clock edge should produce.
  task automatic applyStimulus(input stim_t s);
    bit                loadUse, hazard, front, back, noneBusy;
    logic [NSTAGE-1:0] st, fl;
    logic [NREG-1:0]   busyVec;
    int                nextMode;
    expRec_t           e;
    @(posedge clk);
    #1;
    cycNum++;
    rstN = s.rstn;
    rs1AddrId = s.rs1;       rs2AddrId = s.rs2;
    useRs1Id = s.useRs1;     useRs2Id = s.useRs2;
    rdAddrExe = s.rdExe;     weRegExe = s.weExe;     isLoadExe = s.isLoad;
    llIssue = s.llIssue;     llRd = s.llRd;
    llDone = s.llDone;       llDoneRd = s.llDoneRd;
    errorPrediction = s.ep;  fenceReq = s.fence;     switchMode = s.sw;
    ifStall = s.ifStall;     memStall = s.memStall;

    if (!s.rstn) begin
      modeM = MODE_IDLE;
      cntM  = 0;
      foreach (busyM[r]) busyM[r] = 1'b0;
    end

    loadUse = s.isLoad && s.weExe && (s.rdExe != 0);
    hazard  = (s.useRs1 && (busyM[s.rs1] || (loadUse && (s.rs1 == s.rdExe)))) ||
              (s.useRs2 && (busyM[s.rs2] || (loadUse && (s.rs2 == s.rdExe))));
    back  = s.memStall;
    front = back || hazard;
    noneBusy = 1'b1;
    foreach (busyM[r]) if (busyM[r]) noneBusy = 1'b0;

    if (s.sw || (modeM == MODE_KILL)) begin
      st = '0;
      fl = '0;
      for (int k = 1; k < NSTAGE; k++) fl[k] = 1'b1;
      nextMode = MODE_IDLE;
    end else if (modeM == MODE_DRAIN) begin
      st = stallShape(1'b1, 1'b1, back);
      fl = bubbles(st);
      fl[EXE_IDX] = 1'b1;
      nextMode = (noneBusy && !s.memStall) ? MODE_KILL : MODE_DRAIN;
    end else if (s.ep || ((modeM == MODE_REDIRECT) && s.ifStall)) begin
      st = stallShape(s.ifStall, 1'b0, back);
      st[EXE_IDX] = 1'b0;
      fl = bubbles(st);
      for (int k = 1; k <= EXE_IDX; k++) fl[k] = 1'b1;
      nextMode = s.ifStall ? MODE_REDIRECT : MODE_IDLE;
    end else begin
      st = stallShape(front || s.ifStall, front, back);
      fl = bubbles(st);
      nextMode = ((modeM == MODE_IDLE) && s.fence) ? MODE_DRAIN : MODE_IDLE;
    end

    busyVec = '0;
    foreach (busyM[r]) busyVec[r] = busyM[r];
    e.stall = st;
    e.flush = fl;
    e.busy  = busyVec;
    e.state = 2'(modeM);
    e.cnt   = CNT_W'(cntM);
    expQ.push_back(e);

    if (s.rstn) begin
      for (int r = 1; r < NREG; r++) begin
        if (s.llDone && (int'(s.llDoneRd) == r))     busyM[r] = 1'b0;
        else if (s.llIssue && (int'(s.llRd) == r))   busyM[r] = 1'b1;
      end
      if (st[0] && (cntM < CNT_MAX)) cntM++;
      modeM = nextMode;
    end
  endtask

  task automatic quietCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(quietStim());
  endtask

  // Monitor: the outputs are combinational, so every falling edge presents
  // a response for the stimulus driven after the preceding rising edge.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      monExp = expQ.pop_front();
      checkOutput(monExp);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    rstN = 1'b0;
    rs1AddrId = '0; rs2AddrId = '0; rdAddrExe = '0; llRd = '0; llDoneRd = '0;
    useRs1Id = 1'b0; useRs2Id = 1'b0; weRegExe = 1'b0; isLoadExe = 1'b0;
    llIssue = 1'b0; llDone = 1'b0; errorPrediction = 1'b0; fenceReq = 1'b0;
    switchMode = 1'b0; ifStall = 1'b0; memStall = 1'b0;
    modeM = MODE_IDLE;
    cntM  = 0;
    foreach (busyM[r]) busyM[r] = 1'b0;

    // Reset state
    s = quietStim(); s.rstn = 1'b0;
    applyStimulus(s);
    applyStimulus(s);
    quietCycles(1);

    // Load-use on x5
    s = quietStim(); s.isLoad = 1'b1; s.weExe = 1'b1; s.rdExe = 5'd5;
    s.useRs1 = 1'b1; s.rs1 = 5'd5;
    applyStimulus(s);
    quietCycles(2);

    // Long-latency x7 consumed while busy for ten cycles
    s = quietStim(); s.llIssue = 1'b1; s.llRd = 5'd7;
    applyStimulus(s);
    for (int i = 1; i <= 10; i++) begin
      s = quietStim(); s.useRs1 = 1'b1; s.rs1 = 5'd7;
      if (i == 10) begin s.llDone = 1'b1; s.llDoneRd = 5'd7; end
      applyStimulus(s);
    end
    s = quietStim(); s.useRs1 = 1'b1; s.rs1 = 5'd7;
    applyStimulus(s);
    quietCycles(1);

    // Misprediction while fetch is stalled for three cycles
    s = quietStim(); s.ep = 1'b1; s.ifStall = 1'b1;
    applyStimulus(s);
    s = quietStim(); s.ifStall = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    quietCycles(2);

    // Misprediction with fetch ready, and x0 never becoming busy
    s = quietStim(); s.ep = 1'b1; s.llIssue = 1'b1; s.llRd = 5'd0;
    applyStimulus(s);
    quietCycles(1);

    // Fence waits for x3, then one kill cycle
    s = quietStim(); s.llIssue = 1'b1; s.llRd = 5'd3;
    applyStimulus(s);
    s = quietStim(); s.fence = 1'b1;
    applyStimulus(s);
    quietCycles(3);
    s = quietStim(); s.llDone = 1'b1; s.llDoneRd = 5'd3;
    applyStimulus(s);
    quietCycles(3);

    // Mode switch during a drain keeps the scoreboard
    s = quietStim(); s.llIssue = 1'b1; s.llRd = 5'd9;
    applyStimulus(s);
    s = quietStim(); s.fence = 1'b1;
    applyStimulus(s);
    quietCycles(2);
    s = quietStim(); s.sw = 1'b1;
    applyStimulus(s);
    quietCycles(1);
    s = quietStim(); s.llIssue = 1'b1; s.llRd = 5'd11; s.llDone = 1'b1; s.llDoneRd = 5'd9;
    applyStimulus(s);
    s = quietStim(); s.llIssue = 1'b1; s.llRd = 5'd11; s.llDone = 1'b1; s.llDoneRd = 5'd11;
    applyStimulus(s);

    // Asynchronous reset in the middle of a redirect
    s = quietStim(); s.llIssue = 1'b1; s.llRd = 5'd4;
    applyStimulus(s);
    s = quietStim(); s.ep = 1'b1; s.ifStall = 1'b1;
    applyStimulus(s);
    s = quietStim(); s.ifStall = 1'b1;
    applyStimulus(s);
    s = quietStim(); s.rstn = 1'b0; s.ifStall = 1'b1;
    applyStimulus(s);
    quietCycles(3);

    // Random traffic on a small register window so collisions are common
    for (int i = 0; i < 1500; i++) begin
      s.rstn     = ($urandom_range(0, 299) != 0);
      s.rs1      = AW'($urandom_range(0, 7));
      s.rs2      = AW'($urandom_range(0, 7));
      s.useRs1   = 1'($urandom_range(0, 1));
      s.useRs2   = 1'($urandom_range(0, 1));
      s.rdExe    = AW'($urandom_range(0, 7));
      s.weExe    = ($urandom_range(0, 3) != 0);
      s.isLoad   = ($urandom_range(0, 2) == 0);
      s.llIssue  = ($urandom_range(0, 4) == 0);
      s.llRd     = AW'($urandom_range(0, 7));
      s.llDone   = ($urandom_range(0, 3) == 0);
      s.llDoneRd = AW'($urandom_range(0, 7));
      s.ep       = ($urandom_range(0, 15) == 0);
      s.fence    = ($urandom_range(0, 19) == 0);
      s.sw       = ($urandom_range(0, 59) == 0);
      s.ifStall  = ($urandom_range(0, 3) == 0);
      s.memStall = ($urandom_range(0, 5) == 0);
      applyStimulus(s);
    end

    // Every queued expectation must have been consumed by the monitor
    repeat (2) @(posedge clk);
    checkCount++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL queue_drain: got %0d pending, expected 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
